// File: rtl/sweep_pkg.sv
// Shared types and golden truth tables for the exhaustive-sweep checkers.
package sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

    // Bit i is the required F for vector i, vector MSB is input A.
    localparam logic [15:0] TT_3_31_D = 16'h0DD0;  // F = (A^B)&(C|~D)

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that holds each vector for SETTLE cycles before sampling.
module settle_timer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    if (SETTLE == 0) begin : g_bypass
        // No hold time: the sweeper goes straight from sample to sample.
        logic unused_inputs;
        assign unused_inputs = ^{clk, rst_n, load, en};
        assign zero          = 1'b1;
    end else begin : g_count
        logic [3:0] count_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count_q <= '0;
            end else if (load) begin
                count_q <= 4'(SETTLE - 1);
            end else if (en && count_q != '0) begin
                count_q <= count_q - 1'b1;
            end
        end

        assign zero = (count_q == '0);
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector to a small combinational circuit, captures its truth
// table and scores it against a golden table.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int unsigned         N_IN     = 4,
    parameter int unsigned         SETTLE   = 1,
    parameter logic [2**N_IN-1:0]  EXPECTED = TT_3_31_D
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [N_IN-1:0]      vec,
    input  logic                 resp,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 pass,
    output logic [N_IN:0]        fail_cnt,
    output logic [N_IN-1:0]      first_fail
);

    localparam logic [N_IN-1:0] LAST_IDX  = {N_IN{1'b1}};
    localparam bit              NO_SETTLE = (SETTLE == 0);

    sweep_state_t    state_q, state_d;
    logic [N_IN-1:0] idx_q;
    logic            accept, sampling, last_vec, mismatch;
    logic            timer_load, timer_en, timer_zero;

    assign accept   = (state_q == ST_IDLE) && start;
    assign sampling = (state_q == ST_SAMPLE);
    assign last_vec = (idx_q == LAST_IDX);
    assign mismatch = (resp != EXPECTED[idx_q]);
    assign timer_en = (state_q == ST_WAIT);

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .en    (timer_en),
        .zero  (timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
        state_d    = state_q;
        timer_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = NO_SETTLE ? ST_SAMPLE : ST_WAIT;
                    timer_load = 1'b1;
                end
            end
            ST_WAIT: begin
                if (timer_zero) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (last_vec) begin
                    state_d = ST_DONE;
                end else begin
                    state_d    = NO_SETTLE ? ST_SAMPLE : ST_WAIT;
                    timer_load = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the captured table is reset too, so an aborted sweep never leaves stale bits behind.
            idx_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            table_out  <= '0;
            fail_cnt   <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every register sees the pre-edge values of the others.
            done <= 1'b0;
            if (accept) begin
                idx_q      <= '0;
                busy       <= 1'b1;
                table_out  <= '0;
                fail_cnt   <= '0;
                first_fail <= '0;
                pass       <= 1'b0;
            end else if (sampling) begin
                table_out[idx_q] <= resp;
                if (mismatch) begin
                    fail_cnt <= fail_cnt + 1'b1;
                    if (fail_cnt == '0) begin
                        first_fail <= idx_q;
                    end
                end
                if (last_vec) begin
                    // Score includes the final sample, which lands on this same edge.
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (fail_cnt == '0) && !mismatch;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    // The driven vector is the sweep index itself; it parks on the last vector afterwards.
    assign vec = idx_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: three sweepers (SETTLE 1/0/3) against a cycle-level model
// derived from sweep timing arithmetic, plus directed literal checks.
module tb_truth_table_sweeper;

    localparam int          N_INST = 3;
    localparam logic [15:0] GOLDEN = 16'h0DD0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start      [N_INST];
    logic        resp       [N_INST];
    logic [3:0]  vec        [N_INST];
    logic        busy       [N_INST];
    logic        done       [N_INST];
    logic        pass       [N_INST];
    logic [15:0] table_out  [N_INST];
    logic [4:0]  fail_cnt   [N_INST];
    logic [3:0]  first_fail [N_INST];
    int          mode       [N_INST];

    int n_vec = 0;
    int n_err = 0;

    bit          m_run   [N_INST];
    bit          m_swept [N_INST];
    int          m_k     [N_INST];
    logic [15:0] m_tt    [N_INST];

    always #5 clk = ~clk;

    truth_table_sweeper #(.SETTLE(1)) u_main (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .vec(vec[0]), .resp(resp[0]),
        .busy(busy[0]), .done(done[0]), .table_out(table_out[0]), .pass(pass[0]),
        .fail_cnt(fail_cnt[0]), .first_fail(first_fail[0])
    );

    truth_table_sweeper #(.SETTLE(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .vec(vec[1]), .resp(resp[1]),
        .busy(busy[1]), .done(done[1]), .table_out(table_out[1]), .pass(pass[1]),
        .fail_cnt(fail_cnt[1]), .first_fail(first_fail[1])
    );

    truth_table_sweeper #(.SETTLE(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .vec(vec[2]), .resp(resp[2]),
        .busy(busy[2]), .done(done[2]), .table_out(table_out[2]), .pass(pass[2]),
        .fail_cnt(fail_cnt[2]), .first_fail(first_fail[2])
    );

    // Circuits under exercise: 0 correct, 1 drops the (C|~D) term, 2 stuck at 1.
    function automatic logic dut_f(input int m, input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        case (m)
            0:       return (a ^ b) & (c | ~d);
            1:       return a ^ b;
            default: return 1'b1;
        endcase
    endfunction

    assign resp[0] = dut_f(mode[0], vec[0]);
    assign resp[1] = dut_f(mode[1], vec[1]);
    assign resp[2] = dut_f(mode[2], vec[2]);

    function automatic int settle_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic int sweep_len(input int i);
        return 16 * (settle_of(i) + 1);
    endfunction

    function automatic logic [15:0] table_for(input int m);
        logic [15:0] t;
        for (int v = 0; v < 16; v++) t[v] = dut_f(m, 4'(v));
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: m_k counts edges since the accepting edge; vector v is sampled on edge (v+1)*(SETTLE+1).
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < N_INST; i++) begin
            if (!rst_n) begin
                m_run[i]   <= 1'b0;
                m_swept[i] <= 1'b0;
                m_k[i]     <= 0;
                m_tt[i]    <= '0;
            end else if (m_run[i]) begin
                if (m_k[i] == sweep_len(i)) m_run[i] <= 1'b0;
                else                        m_k[i]   <= m_k[i] + 1;
            end else if (start[i]) begin
                m_run[i]   <= 1'b1;
                m_swept[i] <= 1'b1;
                m_k[i]     <= 0;
                m_tt[i]    <= table_for(mode[i]);
            end
        end
    end

    task automatic check_inst(input int i);
        int          s1, n, ff;
        logic [16:0] m17;
        logic [15:0] mask, diff;
        logic [3:0]  e_vec, e_ff;
        logic        e_busy, e_done, e_pass;
        logic [15:0] e_tab;
        logic [4:0]  e_fc;
        e_vec = '0; e_ff = '0; e_busy = 1'b0; e_done = 1'b0; e_pass = 1'b0;
        e_tab = '0; e_fc = '0;
        s1 = settle_of(i) + 1;
        if (m_swept[i]) begin
            n    = m_k[i] / s1;
            m17  = (17'd1 << n) - 17'd1;
            mask = m17[15:0];
            diff = (m_tt[i] ^ GOLDEN) & mask;
            ff   = 0;
            for (int b = 15; b >= 0; b--) if (diff[b]) ff = b;
            e_vec  = 4'((n > 15) ? 15 : n);
            e_busy = m_run[i] && (m_k[i] < sweep_len(i));
            e_done = m_run[i] && (m_k[i] == sweep_len(i));
            e_tab  = m_tt[i] & mask;
            e_fc   = 5'($countones(diff));
            e_ff   = 4'(ff);
            e_pass = (m_k[i] == sweep_len(i)) && (diff == '0);
        end
        check($sformatf("inst%0d vec", i),        32'(vec[i]),        32'(e_vec));
        check($sformatf("inst%0d busy", i),       32'(busy[i]),       32'(e_busy));
        check($sformatf("inst%0d done", i),       32'(done[i]),       32'(e_done));
        check($sformatf("inst%0d table_out", i),  32'(table_out[i]),  32'(e_tab));
        check($sformatf("inst%0d fail_cnt", i),   32'(fail_cnt[i]),   32'(e_fc));
        check($sformatf("inst%0d first_fail", i), 32'(first_fail[i]), 32'(e_ff));
        check($sformatf("inst%0d pass", i),       32'(pass[i]),       32'(e_pass));
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < N_INST; i++) check_inst(i);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edges counted from the accepting edge (as 1) up to the edge that raises done.
    task automatic run_sweep(input int i, output int edges);
        start[i] = 1'b1;
        tick(1);
        start[i] = 1'b0;
        edges = 1;
        while (done[i] !== 1'b1 && edges < 300) begin
            tick(1);
            edges++;
        end
    endtask

    task automatic check_results(input int i, input string tag, input logic [15:0] tab,
                                 input logic p, input int fc, input int ff);
        check({tag, " table_out"},  32'(table_out[i]),  32'(tab));
        check({tag, " pass"},       32'(pass[i]),       32'(p));
        check({tag, " fail_cnt"},   32'(fail_cnt[i]),   32'(fc));
        check({tag, " first_fail"}, 32'(first_fail[i]), 32'(ff));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " vec"},  32'(vec[0]),  32'd0);
        check({tag, " busy"}, 32'(busy[0]), 32'd0);
        check({tag, " done"}, 32'(done[0]), 32'd0);
        check_results(0, tag, 16'h0000, 1'b0, 0, 0);
    endtask

    initial begin
        int e, dones, cyc;
        rst_n = 1'b0;
        for (int i = 0; i < N_INST; i++) begin
            start[i] = 1'b0;
            mode[i]  = 0;
        end
        tick(2);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(2);

        run_sweep(0, e);
        check("latency settle1", 32'(e), 32'd33);
        check_results(0, "correct", 16'h0DD0, 1'b1, 0, 0);
        tick(3);
        check("vec parks at 15", 32'(vec[0]), 32'd15);

        mode[0] = 1;
        run_sweep(0, e);
        check("latency a_xor_b", 32'(e), 32'd33);
        check_results(0, "a_xor_b", 16'h0FF0, 1'b0, 2, 5);
        tick(2);

        mode[0] = 2;
        run_sweep(0, e);
        check_results(0, "stuck1", 16'hFFFF, 1'b0, 10, 0);
        tick(2);

        // New start clears prior results; starts while busy and in DONE are dropped.
        mode[0]  = 0;
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        check("restart busy", 32'(busy[0]), 32'd1);
        check_results(0, "restart", 16'h0000, 1'b0, 0, 0);
        tick(4);
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        dones = 0;
        cyc   = 0;
        while (cyc < 100) begin
            if (done[0] === 1'b1) begin
                dones++;
                start[0] = (dones == 1);
            end else begin
                start[0] = 1'b0;
            end
            tick(1);
            cyc++;
        end
        check("single done pulse", 32'(dones), 32'd1);
        check("idle after ignored", 32'(busy[0]), 32'd0);
        check_results(0, "after ignored", 16'h0DD0, 1'b1, 0, 0);

        // Asynchronous reset in the middle of vector 7.
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        cyc = 0;
        while (vec[0] !== 4'd7 && cyc < 100) begin
            tick(1);
            cyc++;
        end
        check("reached vec 7", 32'(vec[0]), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1);
        run_sweep(0, e);
        check("latency post reset", 32'(e), 32'd33);
        check_results(0, "post reset", 16'h0DD0, 1'b1, 0, 0);
        tick(2);

        run_sweep(1, e);
        check("latency settle0", 32'(e), 32'd17);
        check_results(1, "settle0", 16'h0DD0, 1'b1, 0, 0);
        tick(2);

        run_sweep(2, e);
        check("latency settle3", 32'(e), 32'd65);
        check_results(2, "settle3", 16'h0DD0, 1'b1, 0, 0);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus/response engine for the 4-input combinational exercise circuits. It is the driving end of their A/B/C/D -> F interface.
- On start, it walks every input vector, waits a settle time, and samples the 1-bit response into a truth-table register.
- It compares the captured table against an expected table and reports pass, mismatch count and first failing index.
- It replaces hand-written exhaustive testbench sequences with a synthesizable, reusable checker.

Parameters:
- N_IN, 4, number of DUT inputs; vector width. Table width is 2**N_IN.
- SETTLE, 1, wait cycles after a vector is driven before sampling. Legal range 0..15.
- EXPECTED, 16'h0DD0, golden truth table. Bit i is the required response for vector i, with vec[N_IN-1] as the MSB (A). The default encodes F = (A^B)&(C|~D).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a sweep; sampled only in IDLE.
- vec  out  N_IN  vector driven to the DUT; vec[N_IN-1]=A ... vec[0]=D.
- resp  in  1  DUT response F.
- busy  out  1  high from the cycle after start acceptance until the last sample.
- done  out  1  one-cycle pulse when the sweep completes.
- table_out  out  2**N_IN  captured truth table; bit i holds resp for vector i.
- pass  out  1  table_out==EXPECTED; valid from done onward.
- fail_cnt  out  N_IN+1  number of mismatching bits.
- first_fail  out  N_IN  lowest failing index; 0 when pass=1.

Behaviour:
- Reset (asynchronous, any state, mid-sweep included): state=IDLE; vec, busy, done, table_out, fail_cnt, first_fail = 0; pass=0; settle counter=0. No partial result survives reset.
- States are IDLE, WAIT, SAMPLE, DONE.
- IDLE:
  - start=1 moves to WAIT (or to SAMPLE if SETTLE=0).
  - On that move: idx=0, vec=0, busy=1, and table_out, fail_cnt, first_fail and pass are cleared.
- WAIT:
  - vec=idx held stable; the counter runs 0..SETTLE-1.
  - Leaves for SAMPLE on the cycle the counter reaches SETTLE-1.
- SAMPLE (one cycle):
  - At the ending edge: table_out[idx] <= resp.
  - If resp != EXPECTED[idx]: fail_cnt increments; first_fail <= idx if this is the first mismatch.
  - If idx < 2**N_IN-1: idx and vec increment together and the state goes to WAIT (or stays in SAMPLE if SETTLE=0).
  - Otherwise: go to DONE.
- DONE (one cycle):
  - done=1, busy=0, pass=(fail_cnt==0). The pass value is registered on entry.
  - Next state is IDLE. Results hold until the next accepted start.
- Latency: the start-accept edge to the done pulse takes exactly 2**N_IN*(SETTLE+1)+1 cycles. With defaults this is 33.
- vec stays at the last vector (all ones) after the sweep and returns to 0 only on the next start or on reset.
- start while busy or in DONE is ignored; there is no queueing. Holding start high relaunches a sweep from IDLE every sweep period.
- Width rules:
  - idx has N_IN bits; the last vector is detected by compare, not by wrap.
  - fail_cnt has N_IN+1 bits, so an all-fail result (2**N_IN) does not overflow.
- resp is sampled only in SAMPLE; changes in other states are ignored. resp is assumed to be driven by combinational logic from vec.

Decomposition:
- Shared package sweep_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_WAIT=2'd1, ST_SAMPLE=2'd2, ST_DONE=2'd3;
  - constant TT_3_31_D=16'h0DD0 and future exercise golden tables.
- One sub-module, settle_timer:
  - loadable down-counter with a zero flag;
  - parameterised by SETTLE; bypassed when SETTLE=0.

Test Plan:
- Correct DUT F=(A^B)&(C|~D), defaults -> after 33 cycles done pulses; table_out=16'h0DD0, pass=1, fail_cnt=0, first_fail=0.
- Faulty DUT F=A^B -> table_out=16'h0FF0, pass=0, fail_cnt=2 (bits 5 and 9), first_fail=5.
- SETTLE=0 and SETTLE=3 -> done at 17 and 65 cycles respectively; vec steps 0..15 in order with the correct hold per value.
- start pulsed while busy, and again in the DONE cycle -> both ignored; exactly one done pulse; a new start in IDLE restarts with cleared results.
- rst_n asserted at vector 7 -> outputs zero immediately (asynchronously); after release with a new start, the full sweep completes normally.
- DUT stuck at 1 -> fail_cnt=10 (16 minus 6 ones), first_fail=0, pass=0.
